wbm_arbiter: RTL and testbench

Parametrised N-master to one-slave Wishbone classic arbiter that merges the core's instruction-fetch and data ports, plus later masters such as a debug unit or DMA, onto a single memory bus. It grants one master per bus cycle using fixed-priority or round-robin policy. The grant is held for the whole `cyc` assertion, so locked and burst sequences stay atomic. A watchdog terminates stalled slave cycles with an error.

---
 rtl/wb_pkg.sv | 16 +
 rtl/wbm_arb_pick.sv | 31 +++
 rtl/wbm_arbiter.sv | 142 ++++++++++++++
 tb/tb_wbm_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants, state type and width helper for the Wishbone master arbiter
package wb_pkg;

    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    function automatic int sel_width(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/wbm_arb_pick.sv
// rtl/wbm_arb_pick.sv - combinational one-hot picker, fixed priority or rotating start point
module wbm_arb_pick #(
    parameter  int N  = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    input  logic          rr_i,
    output logic [N-1:0]  pick_o
);

    logic          found;
    logic [PW-1:0] idx;
    int            base;

    // Scan from the rotating pointer (or from 0), first requester found wins.
    always_comb begin
        pick_o = '0;
        found  = 1'b0;
        idx    = '0;
        base   = rr_i ? int'(ptr_i) : 0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((base + i) % N);
            if (!found && req_i[idx]) begin
                pick_o[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wbm_arbiter.sv
// rtl/wbm_arbiter.sv - N-master to one-slave Wishbone classic arbiter with cycle-long grant and stall watchdog
module wbm_arbiter
    import wb_pkg::*;
#(
    parameter  int N_MASTERS = 2,
    parameter  int AW        = 32,
    parameter  int DW        = 32,
    parameter  int PRIO_MODE = PRIO_FIXED,
    parameter  int TIMEOUT   = 255,
    localparam int SW        = sel_width(DW)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_MASTERS-1:0]    m_cyc_i,
    input  logic [N_MASTERS-1:0]    m_stb_i,
    input  logic [N_MASTERS-1:0]    m_we_i,
    input  logic [N_MASTERS*SW-1:0] m_sel_i,
    input  logic [N_MASTERS*AW-1:0] m_addr_i,
    input  logic [N_MASTERS*DW-1:0] m_dat_i,
    output logic [DW-1:0]           m_dat_o,
    output logic [N_MASTERS-1:0]    m_ack_o,
    output logic [N_MASTERS-1:0]    m_err_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [SW-1:0]           s_sel_o,
    output logic [AW-1:0]           s_addr_o,
    output logic [DW-1:0]           s_dat_o,
    input  logic [DW-1:0]           s_dat_i,
    input  logic                    s_ack_i,
    input  logic                    s_err_i,
    output logic [N_MASTERS-1:0]    grant_o,
    output logic                    timeout_o
);

    localparam int PW = $clog2(N_MASTERS);
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(N_MASTERS - 1);
    localparam logic [CW-1:0] WD_LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_e            state_q, state_d;
    logic [N_MASTERS-1:0]  grant_q, grant_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic [N_MASTERS-1:0]  pick;
    logic [PW-1:0]         gidx;
    logic                  own_cyc, own_stb, own_we;
    logic                  stall, fire;

    wbm_arb_pick #(.N(N_MASTERS)) u_pick (
        .req_i  (m_cyc_i),
        .ptr_i  (ptr_q),
        .rr_i   (PRIO_MODE == PRIO_RR),
        .pick_o (pick)
    );

    // AND-OR mux: with no grant every slave-side signal collapses to zero.
    always_comb begin
        own_cyc  = 1'b0;
        own_stb  = 1'b0;
        own_we   = 1'b0;
        s_sel_o  = '0;
        s_addr_o = '0;
        s_dat_o  = '0;
        gidx     = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            own_cyc  = own_cyc | (m_cyc_i[k] & grant_q[k]);
            own_stb  = own_stb | (m_stb_i[k] & grant_q[k]);
            own_we   = own_we  | (m_we_i[k]  & grant_q[k]);
            s_sel_o  = s_sel_o  | (m_sel_i[k*SW +: SW]  & {SW{grant_q[k]}});
            s_addr_o = s_addr_o | (m_addr_i[k*AW +: AW] & {AW{grant_q[k]}});
            s_dat_o  = s_dat_o  | (m_dat_i[k*DW +: DW]  & {DW{grant_q[k]}});
            if (grant_q[k]) begin
                gidx = PW'(k);
            end
        end
    end

    assign stall = own_cyc & own_stb & ~s_ack_i & ~s_err_i;
    assign fire  = (TIMEOUT != 0) && stall && (cnt_q == WD_LAST);

    // Responses are gated by the owner's cyc so a late ack after an abort goes nowhere.
    assign s_cyc_o   = own_cyc;
    assign s_stb_o   = own_stb & ~fire;
    assign s_we_o    = own_we;
    assign m_dat_o   = s_dat_i;
    assign m_ack_o   = {N_MASTERS{s_ack_i & own_cyc}} & grant_q;
    assign m_err_o   = {N_MASTERS{(s_err_i | fire) & own_cyc}} & grant_q;
    assign grant_o   = grant_q;
    assign timeout_o = fire;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (|m_cyc_i) begin
                    grant_d = pick;
                    state_d = OWNED;
                end
            end
            OWNED: begin
                if (!own_cyc) begin
                    grant_d = '0;
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (PRIO_MODE == PRIO_RR) begin
                        ptr_d = (gidx == LAST_IDX) ? '0 : gidx + PW'(1);
                    end
                end else if (fire || !stall || (TIMEOUT == 0)) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_wbm_arbiter.sv
// tb/tb_wbm_arbiter.sv - self-checking bench: fixed-priority and round-robin instances against a cycle model
module tb_wbm_arbiter;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int SW = DW / 8;
    localparam int TO = 4;
    localparam int NI = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic [N-1:0]    cyc[NI], stb[NI], we[NI];
    logic [N*SW-1:0] sel[NI];
    logic [N*AW-1:0] addr[NI];
    logic [N*DW-1:0] wdat[NI];
    logic [DW-1:0]   sdat[NI];
    logic            sack[NI], serr[NI];

    logic [DW-1:0]   mdat[NI];
    logic [N-1:0]    mack[NI], merr[NI], grant[NI];
    logic            scyc[NI], sstb[NI], swe[NI], tmo[NI];
    logic [SW-1:0]   ssel[NI];
    logic [AW-1:0]   saddr[NI];
    logic [DW-1:0]   sdat_o[NI];

    // Instance 0 is fixed priority, instance 1 is round-robin.
    for (genvar g = 0; g < NI; g++) begin : g_dut
        wbm_arbiter #(.N_MASTERS(N), .AW(AW), .DW(DW), .PRIO_MODE(g), .TIMEOUT(TO)) u_dut (
            .clk_i     (clk),
            .rst_i     (rst_n),
            .m_cyc_i   (cyc[g]),
            .m_stb_i   (stb[g]),
            .m_we_i    (we[g]),
            .m_sel_i   (sel[g]),
            .m_addr_i  (addr[g]),
            .m_dat_i   (wdat[g]),
            .m_dat_o   (mdat[g]),
            .m_ack_o   (mack[g]),
            .m_err_o   (merr[g]),
            .s_cyc_o   (scyc[g]),
            .s_stb_o   (sstb[g]),
            .s_we_o    (swe[g]),
            .s_sel_o   (ssel[g]),
            .s_addr_o  (saddr[g]),
            .s_dat_o   (sdat_o[g]),
            .s_dat_i   (sdat[g]),
            .s_ack_i   (sack[g]),
            .s_err_i   (serr[g]),
            .grant_o   (grant[g]),
            .timeout_o (tmo[g])
        );
    end

    int total = 0;
    int bad   = 0;
    int ovl   = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, want, $time);
        end
    endtask

    // Model: who owns the bus (-1 = nobody), rotation start, consecutive stalled stb cycles.
    int owner[NI], ptr[NI], run[NI];

    function automatic bit stalled(input int g);
        int o;
        o = owner[g];
        if (o < 0) return 1'b0;
        return cyc[g][o] && stb[g][o] && !sack[g] && !serr[g];
    endfunction

    function automatic bit fires(input int g);
        return (TO > 0) && stalled(g) && (run[g] == TO - 1);
    endfunction

    always @(posedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (!rst_n) begin
                owner[g] = -1;
                ptr[g]   = 0;
                run[g]   = 0;
            end else if (owner[g] < 0) begin
                int base, j;
                bit found;
                run[g] = 0;
                base   = (g == 1) ? ptr[g] : 0;
                found  = 1'b0;
                for (int i = 0; i < N; i++) begin
                    j = (base + i) % N;
                    if (!found && cyc[g][j]) begin
                        owner[g] = j;
                        found    = 1'b1;
                    end
                end
            end else if (!cyc[g][owner[g]]) begin
                if (g == 1) ptr[g] = (owner[g] + 1) % N;
                owner[g] = -1;
                run[g]   = 0;
            end else if (fires(g)) begin
                run[g] = 0;
            end else if (stalled(g)) begin
                run[g] = run[g] + 1;
            end else begin
                run[g] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int g = 0; g < NI; g++) begin
                int o;
                bit live, f, wcyc, wstb, wwe;
                logic [N-1:0]  wg, wack, werr;
                logic [SW-1:0] wsel;
                logic [AW-1:0] waddr;
                logic [DW-1:0] wd;
                o    = owner[g];
                live = rst_n && (o >= 0);
                f    = rst_n && fires(g);
                wg   = '0;
                wcyc = 1'b0; wstb = 1'b0; wwe = 1'b0;
                wsel = '0; waddr = '0; wd = '0;
                if (live) begin
                    wg[o] = 1'b1;
                    wcyc  = cyc[g][o];
                    wstb  = stb[g][o] && !f;
                    wwe   = we[g][o];
                    wsel  = sel[g][o*SW +: SW];
                    waddr = addr[g][o*AW +: AW];
                    wd    = wdat[g][o*DW +: DW];
                end
                wack = (live && cyc[g][o] && sack[g]) ? wg : '0;
                werr = (live && cyc[g][o] && (serr[g] || f)) ? wg : '0;
                chk($sformatf("i%0d grant", g),   grant[g],  wg);
                chk($sformatf("i%0d s_cyc", g),   scyc[g],   wcyc);
                chk($sformatf("i%0d s_stb", g),   sstb[g],   wstb);
                chk($sformatf("i%0d s_we", g),    swe[g],    wwe);
                chk($sformatf("i%0d s_sel", g),   ssel[g],   wsel);
                chk($sformatf("i%0d s_addr", g),  saddr[g],  waddr);
                chk($sformatf("i%0d s_dat", g),   sdat_o[g], wd);
                chk($sformatf("i%0d m_ack", g),   mack[g],   wack);
                chk($sformatf("i%0d m_err", g),   merr[g],   werr);
                chk($sformatf("i%0d m_dat", g),   mdat[g],   sdat[g]);
                chk($sformatf("i%0d timeout", g), tmo[g],    f);
                if (rst_n && sack[g] && serr[g]) ovl++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL sim_time_limit actual=running expected=finished");
        $fatal(1);
    end

    logic [N-1:0] log_g[NI][10];
    logic [N-1:0] want_rr[10] = '{3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b000, 3'b100, 3'b100, 3'b000, 3'b001};
    logic [N-1:0] want_fp[10] = '{3'b001, 3'b001, 3'b000, 3'b001, 3'b001, 3'b000, 3'b001, 3'b001, 3'b000, 3'b001};
    logic [N-1:0] a[NI];

    initial begin
        rst_n = 1'b0;
        for (int g = 0; g < NI; g++) begin
            cyc[g] = '1; stb[g] = '1; we[g] = '0; sel[g] = '1;
            addr[g] = '0; wdat[g] = '0; sdat[g] = 16'hA5A5;
            sack[g] = 1'b0; serr[g] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;

        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("i%0d reset grant", g), grant[g], 3'b000);
            chk($sformatf("i%0d reset s_cyc", g), scyc[g], 1'b0);
            chk($sformatf("i%0d reset ack", g), mack[g], 3'b000);
            chk($sformatf("i%0d reset err", g), merr[g], 3'b000);
        end

        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int g = 0; g < NI; g++) sack[g] = 1'b1;
        @(negedge clk);
        for (int g = 0; g < NI; g++) chk($sformatf("i%0d idle after release", g), grant[g], 3'b000);

        // Every master keeps requesting; each drops cyc for one cycle after its ack.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                log_g[g][c] = grant[g];
                a[g]        = mack[g];
            end
            @(posedge clk); #1;
            for (int g = 0; g < NI; g++) begin
                cyc[g] = ~a[g];
                stb[g] = ~a[g];
            end
        end
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("fp grant seq %0d", c), log_g[0][c], want_fp[c]);
            chk($sformatf("rr grant seq %0d", c), log_g[1][c], want_rr[c]);
        end

        for (int g = 0; g < NI; g++) begin
            cyc[g] = '0; stb[g] = '0; sack[g] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < NI; g++) begin
            cyc[g] = 3'b010; stb[g] = 3'b010;
            addr[g][AW +: AW] = 16'h0100;
        end
        @(posedge clk); #1;
        for (int g = 0; g < NI; g++) begin
            cyc[g] = 3'b011; stb[g] = 3'b011; sack[g] = 1'b1;
            addr[g][0 +: AW] = 16'h0BAD;
        end
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < NI; g++) addr[g][AW +: AW] = 16'h0100 + 16'(b);
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                chk($sformatf("i%0d burst addr %0d", g, b), saddr[g], 16'h0100 + 16'(b));
                chk($sformatf("i%0d burst ack %0d", g, b), mack[g], 3'b010);
            end
            @(posedge clk); #1;
        end
        for (int g = 0; g < NI; g++) begin
            cyc[g] = 3'b001; stb[g] = 3'b001; sack[g] = 1'b0;
        end
        @(negedge clk);
        for (int g = 0; g < NI; g++) chk($sformatf("i%0d release cycle grant", g), grant[g], 3'b010);
        @(negedge clk);
        for (int g = 0; g < NI; g++) chk($sformatf("i%0d bubble grant", g), grant[g], 3'b000);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                chk($sformatf("i%0d wd grant %0d", g, i), grant[g], 3'b001);
                chk($sformatf("i%0d wd timeout %0d", g, i), tmo[g], (i == 3) ? 1'b1 : 1'b0);
                chk($sformatf("i%0d wd err %0d", g, i), merr[g], (i == 3) ? 3'b001 : 3'b000);
                chk($sformatf("i%0d wd s_stb %0d", g, i), sstb[g], (i == 3) ? 1'b0 : 1'b1);
            end
        end

        @(posedge clk); #1;
        for (int g = 0; g < NI; g++) begin
            cyc[g] = 3'b011; stb[g] = 3'b011;
        end
        @(posedge clk); #1;
        for (int g = 0; g < NI; g++) begin
            cyc[g] = 3'b010; stb[g] = 3'b010; sack[g] = 1'b1;
        end
        @(negedge clk);
        for (int g = 0; g < NI; g++) chk($sformatf("i%0d abort late ack", g), mack[g], 3'b000);
        @(posedge clk); #1;
        for (int g = 0; g < NI; g++) sack[g] = 1'b0;
        @(negedge clk);
        for (int g = 0; g < NI; g++) chk($sformatf("i%0d abort bubble", g), grant[g], 3'b000);
        @(negedge clk);
        for (int g = 0; g < NI; g++) chk($sformatf("i%0d abort next grant", g), grant[g], 3'b010);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            for (int g = 0; g < NI; g++) begin
                for (int k = 0; k < N; k++) begin
                    if (!cyc[g][k]) cyc[g][k] = ($urandom_range(99) < 30);
                    else if ($urandom_range(99) < 15) cyc[g][k] = 1'b0;
                    stb[g][k] = cyc[g][k] && ($urandom_range(3) != 0);
                    we[g][k]  = 1'($urandom_range(1));
                end
                sel[g]  = (N*SW)'($urandom());
                addr[g] = (N*AW)'({$urandom(), $urandom()});
                wdat[g] = (N*DW)'({$urandom(), $urandom()});
                sdat[g] = DW'($urandom());
                sack[g] = ($urandom_range(99) < 35);
                serr[g] = ($urandom_range(99) < 6);
            end
            if (c == 1502) rst_n = 1'b1;
            if (c == 1500) begin
                #1 rst_n = 1'b0;
            end
        end

        @(negedge clk);
        $display("note: %0d cycles saw slave ack and err together", ovl);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
